// File: rtl/ioctl_ram16_writer.sv
// Packs the ioctl download byte stream into 16-bit little-endian words, queues
// them in a small FIFO and writes them to a 16-bit memory port over req/ack.
module ioctl_ram16_writer #(
  parameter int          DEPTH       = 4,
  parameter logic [23:0] BASE_WORD   = 24'h000000,
  parameter logic [7:0]  INDEX_MASK  = 8'h3F,
  parameter logic [7:0]  INDEX_VALUE = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  // Memory handshake: mem_req rises with addr/din/be already stable and they
  // hold until the cycle mem_ack=1 is sampled; that edge pops the FIFO head
  // and drops mem_req, so consecutive requests are separated by one idle cycle.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_IGNORE, S_ACTIVE, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic   dl_q;
  logic   dl_rise;
  logic   index_match;

  // Pending half-filled word
  logic        pend_valid, pend_valid_d;
  logic [23:0] pend_wa, pend_wa_d;
  logic [7:0]  pend_lo, pend_lo_d;
  logic [7:0]  pend_hi, pend_hi_d;
  logic [1:0]  pend_be, pend_be_d;

  logic [23:0] wa;
  logic        push;
  logic [23:0] push_wa;
  logic [15:0] push_din;
  logic [1:0]  push_be;

  // FIFO entry layout: {word address, data, byte enables}
  logic [41:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          pop, do_push;

  assign dl_rise     = ioctl_download & ~dl_q;
  assign index_match = ((ioctl_index & INDEX_MASK) == INDEX_VALUE);
  assign wa          = ioctl_addr[24:1] + BASE_WORD;
  assign fifo_full   = (count == FULL_CNT);
  assign fifo_empty  = (count == '0);
  assign pop         = mem_req & mem_ack;
  assign do_push     = push & (~fifo_full | pop);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (dl_rise) state_d = index_match ? S_ACTIVE : S_IGNORE;
      S_IGNORE: if (!ioctl_download) state_d = S_IDLE;
      S_ACTIVE: if (!ioctl_download) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_DRAIN;
      S_DRAIN:  if (fifo_empty && !mem_req) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Byte packing; at most one FIFO push per cycle.
  always_comb begin
    push         = 1'b0;
    push_wa      = pend_wa;
    push_din     = {pend_hi, pend_lo};
    push_be      = pend_be;
    pend_valid_d = pend_valid;
    pend_wa_d    = pend_wa;
    pend_lo_d    = pend_lo;
    pend_hi_d    = pend_hi;
    pend_be_d    = pend_be;
    if (state_q == S_ACTIVE && ioctl_wr) begin
      if (pend_valid && ioctl_addr[0] && pend_wa == wa && pend_be == 2'b01) begin
        push         = 1'b1;
        push_din     = {ioctl_dout, pend_lo};
        push_be      = 2'b11;
        pend_valid_d = 1'b0;
      end else if (pend_valid && pend_wa == wa) begin
        // Same word, lane merge (a refilled lane is overwritten)
        if (ioctl_addr[0]) begin
          pend_hi_d = ioctl_dout;
          pend_be_d = pend_be | 2'b10;
        end else begin
          pend_lo_d = ioctl_dout;
          pend_be_d = pend_be | 2'b01;
        end
      end else begin
        // New word; a stale pending word goes out as a partial entry
        push         = pend_valid;
        pend_valid_d = 1'b1;
        pend_wa_d    = wa;
        pend_lo_d    = ioctl_addr[0] ? 8'h00 : ioctl_dout;
        pend_hi_d    = ioctl_addr[0] ? ioctl_dout : 8'h00;
        pend_be_d    = ioctl_addr[0] ? 2'b10 : 2'b01;
      end
    end else if (state_q == S_FLUSH && pend_valid) begin
      push         = 1'b1;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dl_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_wa    <= '0;
      pend_lo    <= '0;
      pend_hi    <= '0;
      pend_be    <= '0;
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      pend_valid <= pend_valid_d;
      pend_wa    <= pend_wa_d;
      pend_lo    <= pend_lo_d;
      pend_hi    <= pend_hi_d;
      pend_be    <= pend_be_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) fifo_mem[wr_ptr] <= {push_wa, push_din, push_be};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Head is copied into the output registers when a request starts.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_be   <= '0;
    end else if (pop) begin
      mem_req <= 1'b0;
    end else if (!mem_req && !fifo_empty) begin
      mem_req                    <= 1'b1;
      {mem_addr, mem_din, mem_be} <= fifo_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_ioctl_ram16_writer.sv
// Directed bench for ioctl_ram16_writer: packing, odd flush, index filter,
// address offset/wrap, FIFO overflow and mid-stream reset.
module tb_ioctl_ram16_writer;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  logic req_q  = 1'b0;

  // {word address, data, byte enables}
  logic [41:0] exp_q[$];

  ioctl_ram16_writer #(
    .DEPTH(4), .BASE_WORD(24'hFFFFF0), .INDEX_MASK(8'h3F), .INDEX_VALUE(8'h00)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_be(mem_be), .mem_ack(mem_ack), .busy(busy),
    .done(done), .overflow(overflow)
  );

  // Clock and event counters
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    req_q <= mem_req;
    if (mem_req && !req_q) req_cnt <= req_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; mem_ack = 1'b0;
    ioctl_index = 8'h00; ioctl_addr = '0; ioctl_dout = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic expect_word(input logic [23:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_q.push_back({a, d, be});
  endtask

  // Scoreboard: serve n requests, acking after ack_delay cycles
  task automatic service(input int n, input int ack_delay);
    logic [41:0] item;
    logic [15:0] mask;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!mem_req && w < 60) begin tick(); w++; end
      check("req_seen", 48'(mem_req), 48'd1);
      if (mem_req && exp_q.size() > 0) begin
        item = exp_q.pop_front();
        mask = {{8{item[1]}}, {8{item[0]}}};
        check("mem_addr", 48'(mem_addr), 48'(item[41:18]));
        check("mem_be", 48'(mem_be), 48'(item[1:0]));
        check("mem_din", 48'(mem_din & mask), 48'(item[17:2] & mask));
      end
      repeat (ack_delay) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("req_drop", 48'(mem_req), 48'd0);
    end
    check("exp_empty", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic wait_done(input int base);
    int w = 0;
    while (done_cnt == base && w < 60) begin tick(); w++; end
    repeat (3) tick();
    check("done_once", 48'(done_cnt - base), 48'd1);
    check("busy_idle", 48'(busy), 48'd0);
  endtask

  initial begin
    int base;
    int rbase;

    // Reset state
    do_reset();
    check("rst_req", 48'(mem_req), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_ovf", 48'(overflow), 48'd0);
    check("rst_addr", 48'(mem_addr), 48'd0);

    // Sequential pair with request latency
    base = done_cnt;
    dl_start(8'h00);
    check("seq_busy", 48'(busy), 48'd1);
    wr_byte(25'h0, 8'h11);
    wr_byte(25'h1, 8'h22);
    check("lat_req0", 48'(mem_req), 48'd0);
    ioctl_download = 1'b0;
    tick();
    check("lat_req1", 48'(mem_req), 48'd1);
    expect_word(24'hFFFFF0, 16'h2211, 2'b11);
    service(1, 2);
    wait_done(base);

    // Odd length: trailing byte flushed with be=01
    base = done_cnt;
    dl_start(8'h00);
    wr_byte(25'h0, 8'hAA);
    wr_byte(25'h1, 8'hBB);
    wr_byte(25'h2, 8'hCC);
    dl_end();
    expect_word(24'hFFFFF0, 16'hBBAA, 2'b11);
    expect_word(24'hFFFFF1, 16'h00CC, 2'b01);
    service(2, 0);
    wait_done(base);

    // Index filter: index 0x02 does not match
    base = done_cnt;
    rbase = req_cnt;
    dl_start(8'h02);
    check("flt_busy", 48'(busy), 48'd1);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'h50 + i));
    dl_end();
    repeat (6) tick();
    check("flt_req", 48'(req_cnt - rbase), 48'd0);
    check("flt_done", 48'(done_cnt - base), 48'd0);
    check("flt_busy0", 48'(busy), 48'd0);

    // Offset wrap, masked index, partial words on address jump
    base = done_cnt;
    dl_start(8'hC0);
    wr_byte(25'h1E, 8'h5A);
    wr_byte(25'h1F, 8'hA5);
    wr_byte(25'h20, 8'h66);
    wr_byte(25'h21, 8'h77);
    wr_byte(25'h24, 8'h99);
    wr_byte(25'h31, 8'h44);
    dl_end();
    expect_word(24'hFFFFFF, 16'hA55A, 2'b11);
    expect_word(24'h000000, 16'h7766, 2'b11);
    expect_word(24'h000002, 16'h0099, 2'b01);
    expect_word(24'h000008, 16'h4400, 2'b10);
    service(4, 1);
    wait_done(base);
    check("wrap_ovf", 48'(overflow), 48'd0);

    // Backpressure: six words into a 4-deep FIFO with no acks
    base = done_cnt;
    dl_start(8'h00);
    for (int i = 0; i < 12; i++) begin
      wr_byte(25'(i), 8'(8'h30 + i));
      if (i == 7) check("ovf_before", 48'(overflow), 48'd0);
      if (i == 9) check("ovf_after", 48'(overflow), 48'd1);
    end
    dl_end();
    expect_word(24'hFFFFF0, 16'h3130, 2'b11);
    expect_word(24'hFFFFF1, 16'h3332, 2'b11);
    expect_word(24'hFFFFF2, 16'h3534, 2'b11);
    expect_word(24'hFFFFF3, 16'h3736, 2'b11);
    service(4, 0);
    wait_done(base);
    check("ovf_sticky", 48'(overflow), 48'd1);

    // Reset mid-stream with two queued words and a live request
    dl_start(8'h00);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'(8'h70 + i));
    tick();
    check("mid_req_pre", 48'(mem_req), 48'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    check("mid_req", 48'(mem_req), 48'd0);
    check("mid_busy", 48'(busy), 48'd0);
    check("mid_ovf", 48'(overflow), 48'd0);
    reset = 1'b0;
    base = done_cnt;
    rbase = req_cnt;
    repeat (10) tick();
    check("mid_done", 48'(done_cnt - base), 48'd0);
    check("mid_noreq", 48'(req_cnt - rbase), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
